register_file: RTL and testbench
================================

Name: register_file

Overview:
- Parametrised successor to the single 8-bit load register in Memory.v.
- Holds DEPTH registers of WIDTH bits.
- Provides one write/modify port with per-cycle operation select (load, increment, clear) and two independently addressed read ports.
- Read ports are registered and have write-to-read bypass.
- Serves as the LittleComputer general-purpose register bank, replacing discrete REGISTER instances.

Parameters:
WIDTH, 8, bits per register
DEPTH, 8, number of registers; power of two, minimum 2
ADDR_W, $clog2(DEPTH), address width (derived; do not override)

Ports:
CLK  input  1  clock; all state updates on rising edge
RESET_N  input  1  asynchronous active-low reset
OP  input  2  write-port operation: 00 NOP, 01 LOAD, 10 INC, 11 CLEAR
WADDR  input  ADDR_W  register targeted by OP
IN  input  WIDTH  data for LOAD
RADDR_A  input  ADDR_W  read port A address
RADDR_B  input  ADDR_W  read port B address
OUT_A  output  WIDTH  registered read data, port A
OUT_B  output  WIDTH  registered read data, port B
CARRY  output  1  set for one cycle when INC wraps the target register
ZERO  output  1  registered flag; target register value after last non-NOP op equals 0

Behaviour:
- Reset, asynchronous on RESET_N low, independent of CLK:
  - all DEPTH registers, OUT_A, OUT_B, CARRY clear to 0.
  - ZERO sets to 1.
  - While RESET_N is low, OP is ignored.
  - Release is synchronous in effect: the first edge with RESET_N high performs a normal update.
- Write port, each rising edge:
  - NOP: no register changes.
  - LOAD: reg[WADDR] <= IN.
  - INC: reg[WADDR] <= reg[WADDR] + 1, modulo 2^WIDTH. All-ones wraps to 0.
  - CLEAR: reg[WADDR] <= 0.
  - Exactly one register is modified per cycle; every other register holds.
- CARRY:
  - 1 in the cycle after an INC whose pre-value was all-ones.
  - Otherwise 0 after every edge, including NOP, LOAD and CLEAR.
- ZERO:
  - Updated only on non-NOP ops, to (new value of reg[WADDR] == 0). Holds on NOP.
  - CLEAR always gives ZERO=1. INC wrap gives ZERO=1 and CARRY=1.
- Read ports:
  - Latency 1 cycle: OUT_x <= value of reg[RADDR_x] as it will be after this edge.
  - Bypass: if RADDR_x == WADDR and OP != NOP in the same cycle, OUT_x shows the newly written value, never the stale one.
  - Applies per port independently. Both ports may address the same register, and may address WADDR simultaneously.
  - OUT_x updates every cycle regardless of OP.
- Address range: all ADDR_W-bit addresses are valid because DEPTH is a power of two. No out-of-range case exists.
- Reset mid-operation: RESET_N asserted between edges clears state immediately. The in-flight op is lost and no partial write occurs.
- No X propagation: outputs are defined from the first reset onward. Behaviour before the first reset is unspecified.

Decomposition:
- Shared header memory_defs.vh holds the OP encodings OP_NOP, OP_LOAD, OP_INC, OP_CLEAR, for use by this block and the future control unit.
- One natural sub-module, register_cell: a WIDTH-bit storage element with asynchronous active-low reset, select, and OP decode. It outputs next value and wrap.
- The top level instantiates DEPTH cells via generate and adds:
  - WADDR decode
  - CARRY/ZERO registers
  - read muxes with bypass

Test Plan:
- Reset: RESET_N=0 for 2 cycles then 1, WIDTH=8 DEPTH=8 -> OUT_A=OUT_B=0, CARRY=0, ZERO=1; every register reads 0 via port A sweep 0..7.
- Load/readback: LOAD 8'h0C to r1, LOAD 8'h4C to r2, then RADDR_A=1, RADDR_B=2 with NOP -> next cycle OUT_A=8'h0C, OUT_B=8'h4C, ZERO=0.
- Bypass: same cycle LOAD 8'hA5 to r3 with RADDR_A=3, RADDR_B=3 -> after that edge OUT_A=OUT_B=8'hA5 (not 0).
- INC wrap: LOAD 8'hFE to r4, INC r4, INC r4 -> values FF then 00; CARRY=0 then 1 then 0 on following NOP; ZERO=1 after wrap, holds 1 on NOP.
- CLEAR and isolation: load r0..r7 with 8'h10+i, CLEAR r5 -> r5=0, ZERO=1, all others unchanged (sweep both ports).
- Async reset mid-op: LOAD 8'hFF to r6 with RESET_N driven low 1 ns before the edge -> r6 reads 0 after release; OUT_A drops to 0 without waiting for CLK.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared definitions for the general-purpose register bank: write-port
// operation encodings and a small decode helper.
package register_file_pkg;

   typedef enum logic [1:0] {
      OP_NOP   = 2'b00,
      OP_LOAD  = 2'b01,
      OP_INC   = 2'b10,
      OP_CLEAR = 2'b11
   } op_e;

   function automatic logic op_writes(input op_e op);
      return (op != OP_NOP);
   endfunction

endpackage

// File: rtl/register_file_cell.sv
// One WIDTH-bit register with local op decode; exposes its next value so the
// top can build read bypass and flags without a second adder.
module register_cell
   import register_file_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             sel_i,
   input  op_e              op_i,
   input  logic [WIDTH-1:0] load_i,
   output logic [WIDTH-1:0] next_o,
   output logic             wrap_o
);

   logic [WIDTH-1:0] value_q;
   logic [WIDTH-1:0] value_d;
   logic             wrap_s;

   // Next-state decode; an unselected cell always holds.
   always_comb begin
      value_d = value_q;
      wrap_s  = 1'b0;
      if (sel_i) begin
         case (op_i)
            OP_LOAD:  value_d = load_i;
            OP_INC:   {wrap_s, value_d} = {1'b0, value_q} + {{WIDTH{1'b0}}, 1'b1};
            OP_CLEAR: value_d = '0;
            default:  value_d = value_q;
         endcase
      end else begin
         value_d = value_q;
      end
   end

   // Storage element.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign next_o = value_d;
   assign wrap_o = wrap_s;

endmodule

// File: rtl/register_file.sv
// DEPTH x WIDTH register bank with one load/inc/clear port and two registered
// read ports that see the value being written in the same cycle.
module register_file
   import register_file_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic [1:0]        OP,
   input  logic [ADDR_W-1:0] WADDR,
   input  logic [WIDTH-1:0]  IN,
   input  logic [ADDR_W-1:0] RADDR_A,
   input  logic [ADDR_W-1:0] RADDR_B,
   output logic [WIDTH-1:0]  OUT_A,
   output logic [WIDTH-1:0]  OUT_B,
   output logic              CARRY,
   output logic              ZERO
);

   op_e              op_s;
   logic [DEPTH-1:0] sel_s;
   logic [DEPTH-1:0] wrap_s;
   logic [WIDTH-1:0] next_s [DEPTH];

   logic [WIDTH-1:0] out_a_q, out_a_d;
   logic [WIDTH-1:0] out_b_q, out_b_d;
   logic             carry_q, carry_d;
   logic             zero_q,  zero_d;

   assign op_s = op_e'(OP);

   for (genvar i = 0; i < DEPTH; i++) begin : g_cell
      assign sel_s[i] = (WADDR == ADDR_W'(i));

      register_cell #(.WIDTH(WIDTH)) u_cell (
         .clk_i  (CLK),
         .rst_ni (RESET_N),
         .sel_i  (sel_s[i]),
         .op_i   (op_s),
         .load_i (IN),
         .next_o (next_s[i]),
         .wrap_o (wrap_s[i])
      );
   end

   // Reading next values gives post-edge contents, so bypass falls out for free.
   always_comb begin
      out_a_d = next_s[RADDR_A];
      out_b_d = next_s[RADDR_B];
      carry_d = |wrap_s;
      if (op_writes(op_s)) begin
         zero_d = (next_s[WADDR] == '0);
      end else begin
         zero_d = zero_q;
      end
   end

   // Registered read data and status flags.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         out_a_q <= '0;
         out_b_q <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b1;
      end else begin
         out_a_q <= out_a_d;
         out_b_q <= out_b_d;
         carry_q <= carry_d;
         zero_q  <= zero_d;
      end
   end

   assign OUT_A = out_a_q;
   assign OUT_B = out_b_q;
   assign CARRY = carry_q;
   assign ZERO  = zero_q;

endmodule

// File: tb/tb_register_file.sv
// Directed vector table, corner sequences and randomized traffic against an
// array-based model of the register bank.
`timescale 1ns/100ps
module tb_register_file;

   logic       CLK = 1'b0;
   logic       RESET_N;
   logic [1:0] OP;
   logic [2:0] WADDR, RADDR_A, RADDR_B;
   logic [7:0] IN, OUT_A, OUT_B;
   logic       CARRY, ZERO;

   int checks = 0;
   int errors = 0;

   logic [7:0] mdl [8];
   logic       mdl_zero, mdl_carry;
   logic [7:0] exp_a, exp_b;

   typedef struct {
      logic [1:0] op;
      logic [2:0] wa;
      logic [7:0] din;
      logic [2:0] ra;
      logic [2:0] rb;
      logic [7:0] ea;
      logic [7:0] eb;
      logic       ec;
      logic       ez;
   } vec_t;

   vec_t vec [10];

   register_file #(.WIDTH(8), .DEPTH(8)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .OP(OP), .WADDR(WADDR), .IN(IN),
      .RADDR_A(RADDR_A), .RADDR_B(RADDR_B), .OUT_A(OUT_A), .OUT_B(OUT_B),
      .CARRY(CARRY), .ZERO(ZERO)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
      mdl_zero  = 1'b1;
      mdl_carry = 1'b0;
   endtask

   // Drive one cycle, advance the model, sample 1 ns after the edge.
   task automatic apply(input logic [1:0] op, input logic [2:0] wa, input logic [7:0] din,
                        input logic [2:0] ra, input logic [2:0] rb);
      int nv;
      OP = op; WADDR = wa; IN = din; RADDR_A = ra; RADDR_B = rb;
      @(posedge CLK);
      nv = int'(mdl[wa]);
      mdl_carry = 1'b0;
      case (op)
         2'd1: nv = int'(din);
         2'd2: begin
            mdl_carry = (nv == 255);
            nv = (nv + 1) % 256;
         end
         2'd3: nv = 0;
         default: ;
      endcase
      mdl[wa] = nv[7:0];
      if (op != 2'd0) mdl_zero = (nv == 0);
      exp_a = mdl[ra];
      exp_b = mdl[rb];
      #1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_out_a"}, {24'd0, OUT_A}, {24'd0, exp_a});
      chk({tag, "_out_b"}, {24'd0, OUT_B}, {24'd0, exp_b});
      chk({tag, "_carry"}, {31'd0, CARRY}, {31'd0, mdl_carry});
      chk({tag, "_zero"},  {31'd0, ZERO},  {31'd0, mdl_zero});
   endtask

   initial begin
      vec[0] = '{2'd1, 3'd1, 8'h0C, 3'd1, 3'd2, 8'h0C, 8'h00, 1'b0, 1'b0};
      vec[1] = '{2'd1, 3'd2, 8'h4C, 3'd1, 3'd2, 8'h0C, 8'h4C, 1'b0, 1'b0};
      vec[2] = '{2'd0, 3'd0, 8'h00, 3'd1, 3'd2, 8'h0C, 8'h4C, 1'b0, 1'b0};
      vec[3] = '{2'd1, 3'd3, 8'hA5, 3'd3, 3'd3, 8'hA5, 8'hA5, 1'b0, 1'b0};
      vec[4] = '{2'd1, 3'd4, 8'hFE, 3'd4, 3'd3, 8'hFE, 8'hA5, 1'b0, 1'b0};
      vec[5] = '{2'd2, 3'd4, 8'h00, 3'd4, 3'd4, 8'hFF, 8'hFF, 1'b0, 1'b0};
      vec[6] = '{2'd2, 3'd4, 8'h00, 3'd4, 3'd4, 8'h00, 8'h00, 1'b1, 1'b1};
      vec[7] = '{2'd0, 3'd4, 8'h00, 3'd4, 3'd1, 8'h00, 8'h0C, 1'b0, 1'b1};
      vec[8] = '{2'd3, 3'd3, 8'h77, 3'd3, 3'd2, 8'h00, 8'h4C, 1'b0, 1'b1};
      vec[9] = '{2'd2, 3'd1, 8'h00, 3'd1, 3'd1, 8'h0D, 8'h0D, 1'b0, 1'b0};

      RESET_N = 1'b0; OP = 2'd0; WADDR = 3'd0; IN = 8'h00; RADDR_A = 3'd0; RADDR_B = 3'd0;
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      chk("reset_out_a", {24'd0, OUT_A}, 32'd0);
      chk("reset_out_b", {24'd0, OUT_B}, 32'd0);
      chk("reset_carry", {31'd0, CARRY}, 32'd0);
      chk("reset_zero",  {31'd0, ZERO},  32'd1);
      RESET_N = 1'b1;
      for (int i = 0; i < 8; i++) begin
         apply(2'd0, 3'd0, 8'h00, 3'(i), 3'(7 - i));
         chk($sformatf("reset_sweep_r%0d", i), {24'd0, OUT_A}, 32'd0);
      end

      for (int i = 0; i < 10; i++) begin
         apply(vec[i].op, vec[i].wa, vec[i].din, vec[i].ra, vec[i].rb);
         chk($sformatf("vec%0d_out_a", i), {24'd0, OUT_A}, {24'd0, vec[i].ea});
         chk($sformatf("vec%0d_out_b", i), {24'd0, OUT_B}, {24'd0, vec[i].eb});
         chk($sformatf("vec%0d_carry", i), {31'd0, CARRY}, {31'd0, vec[i].ec});
         chk($sformatf("vec%0d_zero", i),  {31'd0, ZERO},  {31'd0, vec[i].ez});
      end

      for (int i = 0; i < 8; i++) apply(2'd1, 3'(i), 8'h10 + 8'(i), 3'd0, 3'd0);
      apply(2'd3, 3'd5, 8'hEE, 3'd5, 3'd4);
      chk("clear_out_a", {24'd0, OUT_A}, 32'h00);
      chk("clear_out_b", {24'd0, OUT_B}, 32'h14);
      chk("clear_zero",  {31'd0, ZERO},  32'd1);
      for (int i = 0; i < 8; i++) begin
         apply(2'd0, 3'd2, 8'h00, 3'(i), 3'(7 - i));
         chk($sformatf("iso_a_r%0d", i), {24'd0, OUT_A},
             (i == 5) ? 32'h00 : 32'h10 + 32'(i));
         chk($sformatf("iso_b_r%0d", 7 - i), {24'd0, OUT_B},
             (7 - i == 5) ? 32'h00 : 32'h10 + 32'(7 - i));
      end
      chk("clear_zero_hold", {31'd0, ZERO}, 32'd1);

      for (int n = 0; n < 300; n++) begin
         logic [2:0] wa;
         wa = 3'($urandom_range(0, 7));
         apply(2'($urandom_range(0, 3)), wa,
               ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom),
               ($urandom_range(0, 2) == 0) ? wa : 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)));
         chk_model($sformatf("rnd%0d", n));
      end

      apply(2'd1, 3'd6, 8'h33, 3'd6, 3'd6);
      chk("pre_async_out_a", {24'd0, OUT_A}, 32'h33);
      OP = 2'd1; WADDR = 3'd6; IN = 8'hFF; RADDR_A = 3'd6; RADDR_B = 3'd6;
      #8;
      RESET_N = 1'b0;
      #0.5;
      chk("async_out_a_drop", {24'd0, OUT_A}, 32'd0);
      chk("async_zero",       {31'd0, ZERO},  32'd1);
      @(posedge CLK);
      #1;
      RESET_N = 1'b1;
      model_reset();
      apply(2'd0, 3'd0, 8'h00, 3'd6, 3'd6);
      chk("async_r6_cleared", {24'd0, OUT_A}, 32'd0);
      chk("async_carry",      {31'd0, CARRY}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
